div_tick_timer: RTL

Downstream consumer of the frequency divider's tap outputs (/2, /4, /8, /16). It selects one tap and turns each of its rising edges into a single-cycle `tick` enable in the `clk` domain. It also provides a start/busy/done one-shot timer that counts a programmed number of those ticks. Control logic uses it for slow periodic events without creating derived clocks.

---
 rtl/div_tick_pkg.sv | 21 ++
 rtl/tap_edge_det.sv | 37 +++
 rtl/div_tick_timer.sv | 111 +++++++++++
 3 files changed

// File: rtl/div_tick_pkg.sv
// Shared types and defaults for the divider-tap tick timer.
//   timer_state_t : timer FSM encoding (IDLE, RUN, DONE)
//   TAPS_DEF      : default number of divider taps
//   CNT_W_DEF     : default width of the tick count / remaining value
//   sel_width()   : width of a tap select for a given tap count (min 1)
package div_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int unsigned TAPS_DEF  = 4;
    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_edge_det.sv
// Registered tap history plus select mux; flags a rising edge on the
// selected tap in the current cycle.
//   i_clk     : system clock
//   i_reset   : synchronous active-high reset
//   i_taps    : divider tap outputs, synchronous to i_clk
//   i_sel     : tap to watch this cycle
//   o_edge_c  : combinational rising-edge flag for the selected tap
module tap_edge_det
    import div_tick_pkg::*;
#(
    parameter int unsigned TAPS  = TAPS_DEF,
    parameter int unsigned SEL_W = sel_width(TAPS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [TAPS-1:0]  i_taps,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_edge_c
);

    logic [TAPS-1:0] r_taps_q;

    // History tracks taps even in reset so a tap already high at release
    // is not mistaken for a fresh edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_taps_q <= i_taps;
        end else begin
            r_taps_q <= i_taps;
        end
    end

    // Both current and previous values come from the same register domain,
    // so switching i_sel cannot manufacture an edge by itself.
    assign o_edge_c = i_taps[i_sel] & ~r_taps_q[i_sel];

endmodule

// File: rtl/div_tick_timer.sv
// Turns rising edges of one selected divider tap into single-cycle ticks
// and runs a one-shot timer that counts a programmed number of those ticks.
//   i_clk       : system clock, all logic on rising edge
//   i_reset     : synchronous active-high reset
//   i_taps      : divider taps (bit0=/2, bit1=/4, bit2=/8, bit3=/16)
//   i_sel       : tap select (latched for the duration of a run)
//   i_start     : one-cycle start request, honoured only in IDLE
//   i_count     : number of ticks to time, sampled with i_start
//   o_tick      : one-cycle pulse per rising edge of the active tap
//   o_busy      : timer running
//   o_done      : one-cycle pulse on expiry
//   o_remaining : ticks left in the current run
module div_tick_timer
    import div_tick_pkg::*;
#(
    parameter int unsigned TAPS  = TAPS_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned SEL_W = sel_width(TAPS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [TAPS-1:0]  i_taps,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_remaining
);

    timer_state_t     r_state;
    logic [SEL_W-1:0] r_sel_l;
    logic [CNT_W-1:0] r_remaining;
    logic             r_tick;
    logic             r_busy;
    logic             r_done;
    logic [SEL_W-1:0] w_sel_a;
    logic             w_edge;

    // Live select while idle; latched select while a run is in flight.
    assign w_sel_a = (r_state == IDLE) ? i_sel : r_sel_l;

    tap_edge_det #(
        .TAPS  (TAPS),
        .SEL_W (SEL_W)
    ) u_edge (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_taps   (i_taps),
        .i_sel    (w_sel_a),
        .o_edge_c (w_edge)
    );

    // Timer FSM; busy/done are registered alongside the state they decode.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_sel_l     <= '0;
            r_remaining <= '0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tick <= w_edge;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sel_l <= i_sel;
                        if (i_count != '0) begin
                            r_remaining <= i_count;
                            r_state     <= RUN;
                            r_busy      <= 1'b1;
                        end else begin
                            // Zero-length run: report done without going busy.
                            r_remaining <= '0;
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Only path that decrements; remaining is >= 1 here.
                    if (w_edge) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick      = r_tick;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_remaining = r_remaining;

endmodule
